// File: rtl/count8_down_timer.sv
// count8_down_timer
// Loadable down-counter/timer. A load strobe captures a start value, which
// also becomes the reload value. While running, the count decrements once per
// enabled cycle. Reaching zero raises a one-cycle TC pulse, then either stops
// (one-shot, DONE) or reloads (periodic).
//
// Ports:
//   clk     in   system clock, rising edge
//   res     in   asynchronous active-low reset
//   EN      in   count enable (used only while running)
//   load    in   synchronous load/start strobe
//   CNT_In  in   start/reload value (WIDTH bits)
//   reload  in   auto-reload mode, captured with load
//   abort   in   synchronous stop back to idle
//   CNT     out  current count
//   TC      out  terminal-count pulse, one cycle wide
//   BUSY    out  counter is running
//   DONE    out  one-shot has finished
//
// state  | meaning
// S_IDLE | stopped after reset or abort, count is zero
// S_RUN  | counting down on enabled cycles
// S_DONE | one-shot expired, waiting for the next load or abort

module count8_down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load,
    input  logic [WIDTH-1:0] CNT_In,
    input  logic             reload,
    input  logic             abort,
    output logic [WIDTH-1:0] CNT,
    output logic             TC,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_rld;
    logic             r_arm;
    logic             r_tc;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_rld_nxt;
    logic             w_arm_nxt;
    logic             w_tc_nxt;
    logic [WIDTH-1:0] w_dec;
    logic             w_cnt_is_one;

    // Decrement as r_cnt + all-ones with a rippled carry. With the second
    // operand fixed at 1 the sum bit reduces to ~(a ^ c) and the carry to a | c.
    // The final carry-out is discarded.
    always_comb begin
        logic carry;
        carry = 1'b0;
        w_dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_dec[i] = ~(r_cnt[i] ^ carry);
            carry    = r_cnt[i] | carry;
        end
    end

    assign w_cnt_is_one = (r_cnt == WIDTH'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rld_nxt   = r_rld;
        w_arm_nxt   = r_arm;
        w_tc_nxt    = 1'b0;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (load) begin
            w_cnt_nxt = CNT_In;
            w_rld_nxt = CNT_In;
            w_arm_nxt = reload;
            if (CNT_In != '0) begin
                w_state_nxt = S_RUN;
            end else begin
                // Zero-length timer expires at once, even in reload mode,
                // so it never spins reloading zero.
                w_state_nxt = S_DONE;
                w_tc_nxt    = 1'b1;
            end
        end else if (r_state == S_RUN && EN) begin
            if (w_cnt_is_one) begin
                w_tc_nxt = 1'b1;
                if (r_arm) begin
                    w_cnt_nxt = r_rld;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end
            end else begin
                w_cnt_nxt = w_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rld   <= '0;
            r_arm   <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rld   <= w_rld_nxt;
            r_arm   <= w_arm_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign CNT  = r_cnt;
    assign TC   = r_tc;
    assign BUSY = (r_state == S_RUN);
    assign DONE = (r_state == S_DONE);

endmodule

// File: tb/tb_count8_down_timer.sv
// Testbench for count8_down_timer: directed scenarios with literal expectations
// plus randomized traffic, every cycle compared against a behavioural model.
`timescale 1ns/1ps

module tb_count8_down_timer;

    logic       clk = 1'b0;
    logic       res;
    logic       EN;
    logic       load;
    logic [7:0] CNT_In;
    logic       reload;
    logic       abort;
    logic [7:0] CNT;
    logic       TC;
    logic       BUSY;
    logic       DONE;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 = idle, 1 = running, 2 = finished
    int m_cnt, m_rld, m_arm, m_mode, m_tc;

    count8_down_timer #(.WIDTH(8)) dut (
        .clk    (clk),
        .res    (res),
        .EN     (EN),
        .load   (load),
        .CNT_In (CNT_In),
        .reload (reload),
        .abort  (abort),
        .CNT    (CNT),
        .TC     (TC),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_rld = 0; m_arm = 0; m_mode = 0; m_tc = 0;
    endtask

    task automatic model_edge();
        if (!res) begin
            model_reset();
        end else begin
            m_tc = 0;
            if (abort) begin
                m_mode = 0;
                m_cnt  = 0;
            end else if (load) begin
                m_cnt = int'(CNT_In);
                m_rld = int'(CNT_In);
                m_arm = int'(reload);
                if (CNT_In != 0) m_mode = 1;
                else begin
                    m_mode = 2;
                    m_tc   = 1;
                end
            end else if (m_mode == 1 && EN) begin
                if (m_cnt == 1) begin
                    m_tc = 1;
                    if (m_arm != 0) m_cnt = m_rld;
                    else begin
                        m_cnt  = 0;
                        m_mode = 2;
                    end
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    endtask

    task automatic compare();
        check("CNT",  int'(CNT),  m_cnt);
        check("TC",   int'(TC),   m_tc);
        check("BUSY", int'(BUSY), (m_mode == 1) ? 1 : 0);
        check("DONE", int'(DONE), (m_mode == 2) ? 1 : 0);
    endtask

    // One clock: drive inputs, take the edge, update model, compare on the falling edge.
    task automatic cycle(input logic en, input logic ld, input logic [7:0] din,
                         input logic rl, input logic ab);
        EN = en; load = ld; CNT_In = din; reload = rl; abort = ab;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    int tc_seen;
    int edges;
    int seq_ok;
    int exp_seq[6] = '{3, 2, 1, 3, 2, 1};
    int seq_idx;

    initial begin
        res = 1'b0; EN = 1'b0; load = 1'b0; CNT_In = 8'h00; reload = 1'b0; abort = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        res = 1'b1;

        // One-shot of 5
        cycle(1, 1, 8'd5, 0, 0);
        check("load5_cnt",  int'(CNT),  5);
        check("load5_busy", int'(BUSY), 1);
        tc_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 8'd0, 0, 0);
            tc_seen += int'(TC);
        end
        check("oneshot_cnt0", int'(CNT), 0);
        check("oneshot_tc",   int'(TC),  1);
        check("oneshot_busy", int'(BUSY), 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 8'd0, 0, 0);
            tc_seen += int'(TC);
        end
        check("oneshot_done_held", int'(DONE), 1);
        check("oneshot_tc_count", tc_seen, 1);

        // Auto-reload 3 with EN toggling
        cycle(1, 1, 8'd3, 1, 0);
        tc_seen = 0; seq_ok = 1; seq_idx = 0;
        if (CNT != 8'd3) seq_ok = 0;
        seq_idx = 1;
        for (int i = 0; i < 12; i++) begin
            cycle(i[0] == 1'b0, 0, 8'd0, 0, 0);
            tc_seen += int'(TC);
            if (i[0] == 1'b0 && seq_idx < 6) begin
                if (int'(CNT) != exp_seq[seq_idx]) seq_ok = 0;
                seq_idx++;
            end
        end
        check("reload_seq", seq_ok, 1);
        check("reload_tc_count", tc_seen, 2);
        check("reload_no_done", int'(DONE), 0);

        // Zero-length timer in reload mode
        cycle(1, 1, 8'd0, 1, 0);
        check("zero_done", int'(DONE), 1);
        check("zero_tc",   int'(TC),   1);
        check("zero_busy", int'(BUSY), 0);
        cycle(1, 0, 8'd0, 0, 0);
        check("zero_tc_clear", int'(TC), 0);

        // Maximum value
        cycle(1, 1, 8'hFF, 0, 0);
        edges = 0;
        while (TC == 1'b0 && edges < 300) begin
            cycle(1, 0, 8'd0, 0, 0);
            edges++;
        end
        check("max_edges", edges, 255);
        check("max_cnt", int'(CNT), 0);
        cycle(1, 0, 8'd0, 0, 0);
        check("max_nowrap", int'(CNT), 0);

        // Load collides with expiry
        cycle(1, 1, 8'd2, 0, 0);
        cycle(1, 0, 8'd0, 0, 0);
        check("col_pre", int'(CNT), 1);
        cycle(1, 1, 8'h10, 0, 0);
        check("col_load_cnt", int'(CNT), 16);
        check("col_load_tc",  int'(TC),  0);

        // Abort collides with expiry
        cycle(1, 1, 8'd2, 0, 0);
        cycle(1, 0, 8'd0, 0, 0);
        cycle(1, 0, 8'd0, 0, 1);
        check("abort_cnt",  int'(CNT),  0);
        check("abort_tc",   int'(TC),   0);
        check("abort_busy", int'(BUSY), 0);
        check("abort_done", int'(DONE), 0);

        // Reload mid-count
        cycle(1, 1, 8'h25, 0, 0);
        repeat (5) cycle(1, 0, 8'd0, 0, 0);
        check("mid_cnt", int'(CNT), 32);
        cycle(1, 1, 8'd4, 0, 0);
        check("mid_load", int'(CNT), 4);
        tc_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 8'd0, 0, 0);
            tc_seen += int'(TC);
        end
        check("mid_tc_count", tc_seen, 1);
        check("mid_done", int'(DONE), 1);

        // Asynchronous reset mid-count at 0x37
        cycle(1, 1, 8'h40, 1, 0);
        repeat (9) cycle(1, 0, 8'd0, 0, 0);
        check("rst_pre_cnt", int'(CNT), 55);
        #2 res = 1'b0;
        #1;
        model_reset();
        check("rst_async_cnt",  int'(CNT),  0);
        check("rst_async_tc",   int'(TC),   0);
        check("rst_async_busy", int'(BUSY), 0);
        check("rst_async_done", int'(DONE), 0);
        @(negedge clk);
        compare();
        res = 1'b1;
        repeat (4) cycle(1, 0, 8'd0, 0, 0);
        check("rst_after_cnt",  int'(CNT),  0);
        check("rst_after_busy", int'(BUSY), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 6));
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  v,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
